// File: rtl/serial_out_arbiter.sv
// serial_out_arbiter: round-robin arbiter that feeds one A/D/Go serial out buffer from NREQ requesters
module serial_out_arbiter #(
   parameter int NREQ         = 4,
   parameter int FRAME_CYCLES = 16,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 en,
   input  logic [NREQ-1:0]      req,
   input  logic [7*NREQ-1:0]    req_addr,
   input  logic [8*NREQ-1:0]    req_data,
   output logic [NREQ-1:0]      ack,
   output logic [6:0]           A,
   output logic [7:0]           D,
   output logic                 Go,
   output logic                 busy,
   output logic [2:0]           grant_idx
);
   localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, LAUNCH, FRAME, GAP} state_t;
   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [NREQ-1:0] ack_n;
   logic [6:0]      a_n;
   logic [7:0]      d_n;
   logic            go_n;
   logic [2:0]      gi_n;
   int              hi_win, lo_win, win;
   logic            hi_found, lo_found;
   assign busy = state != IDLE;
   // round-robin pick: lowest requester above the last grant, else lowest at or below it
   always_comb begin
      hi_win = 0;
      lo_win = 0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i] && i > int'(grant_idx)) begin
            hi_win = i;
            hi_found = 1'b1;
         end
         if (req[i] && i <= int'(grant_idx)) begin
            lo_win = i;
            lo_found = 1'b1;
         end
      end
      win = hi_found ? hi_win : lo_win;
   end
   // next-state and next-output logic for the launch/frame/gap sequence
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ack_n   = '0;
      go_n    = 1'b0;
      a_n     = A;
      d_n     = D;
      gi_n    = grant_idx;
      case (state)
         IDLE: if (en && (hi_found || lo_found)) begin
            a_n     = 7'(req_addr >> (7 * win));
            d_n     = 8'(req_data >> (8 * win));
            ack_n   = NREQ'(1) << win;
            gi_n    = 3'(win);
            state_n = LAUNCH;
         end
         LAUNCH: begin
            go_n    = 1'b1;
            cnt_n   = CW'(FRAME_CYCLES - 1);
            state_n = FRAME;
         end
         FRAME: if (cnt == '0) begin
            cnt_n   = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
            state_n = GAP_CYCLES > 0 ? GAP : IDLE;
         end else begin
            cnt_n = cnt - 1'b1;
         end
         GAP: if (cnt == '0) state_n = IDLE;
              else cnt_n = cnt - 1'b1;
         default: state_n = IDLE;
      endcase
   end
   // state, counter and registered outputs; reset abandons any frame in flight
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ack       <= '0;
         Go        <= 1'b0;
         A         <= '0;
         D         <= '0;
         grant_idx <= 3'(NREQ - 1);
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ack       <= ack_n;
         Go        <= go_n;
         A         <= a_n;
         D         <= d_n;
         grant_idx <= gi_n;
      end
   end
endmodule

// File: tb/tb_serial_out_arbiter.sv
// tb_serial_out_arbiter: directed self-checking bench for serial_out_arbiter
module tb_serial_out_arbiter;
   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  req = '0;
   logic [27:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack;
   logic [6:0]  A;
   logic [7:0]  D;
   logic        Go;
   logic        busy;
   logic [2:0]  grant_idx;
   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   int go_cyc = 0;
   int prev_go = 0;
   int n = 0;
   logic [6:0] ea [4] = '{7'h7E, 7'h41, 7'h2A, 7'h13};
   logic [7:0] ed [4] = '{8'h5A, 8'h69, 8'hD2, 8'h3C};

   serial_out_arbiter dut (
      .clk_in(clk_in), .reset(reset), .en(en), .req(req),
      .req_addr(req_addr), .req_data(req_data), .ack(ack),
      .A(A), .D(D), .Go(Go), .busy(busy), .grant_idx(grant_idx)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk_in);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 30; i++) begin
         if (ack != '0) break;
         cyc(1);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         cyc(1);
      end
      chk("idle_reached", busy, 0);
   endtask

   task automatic run_frame(input logic [3:0] e_ack, input logic [6:0] e_a, input logic [7:0] e_d,
                            input logic [3:0] req_after);
      int len;
      chk("ack", ack, e_ack);
      chk("ack_A", A, e_a);
      chk("ack_D", D, e_d);
      chk("ack_busy", busy, 1);
      chk("ack_nogo", Go, 0);
      req = req_after;
      cyc(1);
      go_cyc = cyc_cnt;
      chk("go", Go, 1);
      chk("go_ack_clear", ack, 0);
      chk("go_A", A, e_a);
      chk("go_D", D, e_d);
      len = 2;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (!busy) break;
         len++;
         chk("go_single", Go, 0);
         chk("hold_A", A, e_a);
         chk("hold_D", D, e_d);
      end
      chk("busy_len", len, 19);
   endtask

   initial begin
      en = 1'b1;
      cyc(2);
      chk("rst_A", A, 0);
      chk("rst_D", D, 0);
      chk("rst_Go", Go, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gidx", grant_idx, 3);
      reset = 1'b0;
      req_addr = {21'h0, 7'h55};
      req_data = {24'h0, 8'hA3};
      req = 4'b0001;
      wait_ack();
      run_frame(4'b0001, 7'h55, 8'hA3, 4'b0000);
      chk("t1_gidx", grant_idx, 0);

      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("t2_gidx_rst", grant_idx, 3);
      req_addr = {7'h13, 7'h2A, 7'h41, 7'h7E};
      req_data = {8'h3C, 8'hD2, 8'h69, 8'h5A};
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_ack();
         prev_go = go_cyc;
         run_frame(4'(1 << (f % 4)), ea[f % 4], ed[f % 4], f == 4 ? 4'b0000 : 4'b1111);
         if (f > 0) chk("go_spacing", go_cyc - prev_go, 20);
      end

      req = 4'b0010;
      wait_ack();
      run_frame(4'b0010, ea[1], ed[1], 4'b0000);
      chk("t3_gidx", grant_idx, 1);
      req = 4'b1001;
      wait_ack();
      run_frame(4'b1000, ea[3], ed[3], 4'b0001);
      wait_ack();
      run_frame(4'b0001, ea[0], ed[0], 4'b0000);

      en = 1'b0;
      req = 4'b0010;
      cyc(1);
      chk("en0_ack", ack, 0);
      chk("en0_busy", busy, 0);
      cyc(1);
      chk("en0_ack2", ack, 0);
      chk("en0_go", Go, 0);
      en = 1'b1;
      cyc(1);
      chk("en1_ack", ack, 4'b0010);
      chk("en1_gidx", grant_idx, 1);
      req = 4'b0000;
      cyc(1);
      chk("en1_go", Go, 1);
      cyc(1);
      en = 1'b0;
      req = 4'b0100;
      n = 2;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         n++;
         cyc(1);
      end
      chk("en_drop_busy_len", n, 19);
      cyc(1);
      chk("en_drop_ack", ack, 0);
      chk("en_drop_busy", busy, 0);
      cyc(1);
      chk("en_drop_ack2", ack, 0);
      en = 1'b1;
      wait_ack();
      run_frame(4'b0100, ea[2], ed[2], 4'b0000);

      req = 4'b0001;
      wait_ack();
      chk("t5_ack", ack, 4'b0001);
      req = 4'b0000;
      cyc(1);
      chk("t5_go", Go, 1);
      cyc(4);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_Go", Go, 0);
      chk("arst_A", A, 0);
      chk("arst_D", D, 0);
      chk("arst_ack", ack, 0);
      chk("arst_gidx", grant_idx, 3);
      cyc(1);
      reset = 1'b0;
      req = 4'b0100;
      wait_ack();
      run_frame(4'b0100, ea[2], ed[2], 4'b0000);

      req = 4'b0001;
      wait_ack();
      chk("t6_ack", ack, 4'b0001);
      req = 4'b0000;
      cyc(1);
      chk("t6_go", Go, 1);
      cyc(3);
      req = 4'b0010;
      cyc(1);
      req = 4'b0000;
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("withdrawn_ack", ack, 0);
         chk("withdrawn_busy", busy, 0);
      end
      chk("t6_gidx", grant_idx, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
